// File: rtl/keccak_padder_param.sv
// keccak_padder_param: parametrised Keccak pad10*1 padder with runtime domain separation.
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   in, in_ready    : message word (byte 0 in the top byte) and its valid strobe
//   is_last         : word is the message tail carrying byte_num valid bytes
//   byte_num, dsep  : valid byte count of the tail and the domain-separation byte
//   buffer_full     : input is not accepted this cycle
//   out, out_ready  : assembled RATE-bit block and its valid flag
//   last_block      : block is the final block of the message
//   f_ack           : permutation has consumed out
module keccak_padder_param #(
    parameter int RATE = 576,
    parameter int IN_W = 64,
    parameter int BN_W = $clog2(IN_W / 8)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IN_W-1:0] in,
    input  logic            in_ready,
    input  logic            is_last,
    input  logic [BN_W-1:0] byte_num,
    input  logic [7:0]      dsep,
    output logic            buffer_full,
    output logic [RATE-1:0] out,
    output logic            out_ready,
    output logic            last_block,
    input  logic            f_ack
);
    localparam int WORDS = RATE / IN_W;
    localparam int NB = IN_W / 8;
    localparam int CW = $clog2(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {ABSORB, PAD, FULL} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            last_seen, seen_n;
    logic [IN_W-1:0] tail, word;
    logic            accept, shift, pad_act;

    assign accept      = state == ABSORB && in_ready;
    assign shift       = accept || state == PAD;
    assign pad_act     = state == PAD || (accept && is_last);
    assign buffer_full = state != ABSORB;
    assign out_ready   = state == FULL;
    assign last_block  = last_seen && out_ready;

    // Tail word: kept bytes, then dsep, then zeros.
    always_comb begin
        tail = '0;
        for (int i = 0; i < NB; i++)
            tail[IN_W-1-8*i -: 8] = (BN_W'(i) < byte_num) ? in[IN_W-1-8*i -: 8] :
                                    (BN_W'(i) == byte_num) ? dsep : 8'h00;
    end

    // The closing 1 of pad10*1 is bit 7 of the block's final byte.
    always_comb begin
        word = state == PAD ? '0 : is_last ? tail : in;
        word[7] = word[7] | (pad_act && cnt == LAST);
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        seen_n = last_seen;
        case (state)
            ABSORB: if (in_ready) begin
                seen_n = last_seen | is_last;
                cnt_n = cnt == LAST ? '0 : cnt + CW'(1);
                state_n = cnt == LAST ? FULL : is_last ? PAD : ABSORB;
            end
            PAD: begin
                cnt_n = cnt == LAST ? '0 : cnt + CW'(1);
                state_n = cnt == LAST ? FULL : PAD;
            end
            FULL: if (f_ack) begin
                state_n = ABSORB;
                seen_n = 1'b0;
            end
            default: state_n = ABSORB;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ABSORB;
            cnt <= '0;
            last_seen <= 1'b0;
            out <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            last_seen <= seen_n;
            if (shift) out <= {out[RATE-IN_W-1:0], word};
        end
    end
endmodule

// File: tb/tb_keccak_padder_param.sv
// tb_keccak_padder_param: directed bench for keccak_padder_param at RATE=576, IN_W=64.
module tb_keccak_padder_param;
    localparam logic [63:0]  W1      = 64'h90abcdef11111111;
    localparam logic [575:0] EMPTY06 = {8'h06, 560'h0, 8'h80};
    localparam logic [575:0] EMPTY1F = {8'h1f, 560'h0, 8'h80};
    localparam logic [575:0] BLK1    = {9{W1}};
    localparam logic [575:0] BLK2    = {64'hfc7b8c1f00000000, 448'h0, 64'h0000000000000080};
    localparam logic [575:0] BLK3    = {{8{W1}}, 64'h010203040506079f};
    localparam logic [575:0] BLK4    = {64'haabb060000000000, 448'h0, 64'h0000000000000080};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [63:0]  in_word = '0;
    logic         in_ready = 1'b0;
    logic         is_last = 1'b0;
    logic [2:0]   byte_num = '0;
    logic [7:0]   dsep = '0;
    logic         buffer_full;
    logic [575:0] out;
    logic         out_ready;
    logic         last_block;
    logic         f_ack = 1'b0;
    int           vectors = 0;
    int           errors = 0;

    keccak_padder_param dut (
        .clk(clk), .reset(reset), .in(in_word), .in_ready(in_ready), .is_last(is_last),
        .byte_num(byte_num), .dsep(dsep), .buffer_full(buffer_full), .out(out),
        .out_ready(out_ready), .last_block(last_block), .f_ack(f_ack)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [63:0] w, input logic last, input logic [2:0] bn, input logic [7:0] ds);
        @(negedge clk);
        in_word = w; in_ready = 1'b1; is_last = last; byte_num = bn; dsep = ds;
        @(posedge clk);
        #1 in_ready = 1'b0; is_last = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!out_ready && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic ack;
        @(negedge clk);
        f_ack = 1'b1;
        @(posedge clk);
        #1 f_ack = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_word = {$urandom, $urandom}; in_ready = 1'($urandom); is_last = 1'($urandom);
            f_ack = 1'($urandom); dsep = 8'($urandom);
        end
        in_ready = 1'b0; is_last = 1'b0; f_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++; if (out !== '0) begin errors++; $display("FAIL reset_out got %h want 0", out); end
        vectors++; if (out_ready !== 1'b0) begin errors++; $display("FAIL reset_out_ready got %b want 0", out_ready); end
        vectors++; if (buffer_full !== 1'b0) begin errors++; $display("FAIL reset_buffer_full got %b want 0", buffer_full); end
        vectors++; if (last_block !== 1'b0) begin errors++; $display("FAIL reset_last_block got %b want 0", last_block); end
    endtask

    task automatic test_empty_sha3;
        int n;
        send(64'h0, 1'b1, 3'd0, 8'h06);
        wait_ready(n);
        vectors++; if (n !== 8) begin errors++; $display("FAIL empty_latency got %0d want 8", n); end
        vectors++; if (out !== EMPTY06) begin errors++; $display("FAIL empty_block got %h want %h", out, EMPTY06); end
        vectors++; if (last_block !== 1'b1) begin errors++; $display("FAIL empty_last_block got %b want 1", last_block); end
        ack;
        vectors++; if (out_ready !== 1'b0 || last_block !== 1'b0) begin errors++; $display("FAIL empty_after_ack got %b%b want 00", out_ready, last_block); end
    endtask

    task automatic test_full_then_tail;
        int n;
        for (int i = 0; i < 9; i++) send(W1, 1'b0, 3'd0, 8'h00);
        wait_ready(n);
        vectors++; if (n !== 0) begin errors++; $display("FAIL full_latency got %0d want 0", n); end
        vectors++; if (out !== BLK1) begin errors++; $display("FAIL full_block got %h want %h", out, BLK1); end
        vectors++; if (last_block !== 1'b0) begin errors++; $display("FAIL full_last_block got %b want 0", last_block); end
        ack;
        send(64'hfc7b8cda12345678, 1'b1, 3'd3, 8'h1f);
        wait_ready(n);
        vectors++; if (n !== 8) begin errors++; $display("FAIL tail_latency got %0d want 8", n); end
        vectors++; if (out !== BLK2) begin errors++; $display("FAIL tail_block got %h want %h", out, BLK2); end
        vectors++; if (last_block !== 1'b1) begin errors++; $display("FAIL tail_last_block got %b want 1", last_block); end
        ack;
    endtask

    task automatic test_boundary;
        int n;
        for (int i = 0; i < 8; i++) send(W1, 1'b0, 3'd0, 8'h00);
        send(64'h0102030405060708, 1'b1, 3'd7, 8'h1f);
        wait_ready(n);
        vectors++; if (n !== 0) begin errors++; $display("FAIL boundary_latency got %0d want 0", n); end
        vectors++; if (out !== BLK3) begin errors++; $display("FAIL boundary_block got %h want %h", out, BLK3); end
        vectors++; if (last_block !== 1'b1) begin errors++; $display("FAIL boundary_last_block got %b want 1", last_block); end
        vectors++; if (buffer_full !== 1'b1) begin errors++; $display("FAIL boundary_buffer_full got %b want 1", buffer_full); end
        ack;
    endtask

    task automatic test_handshake_abuse;
        int n;
        ack;
        vectors++; if (out_ready !== 1'b0 || buffer_full !== 1'b0) begin errors++; $display("FAIL stray_ack got %b%b want 00", out_ready, buffer_full); end
        vectors++; if (out !== BLK3) begin errors++; $display("FAIL stray_ack_out got %h want %h", out, BLK3); end
        send(64'haabbccddeeff0011, 1'b1, 3'd2, 8'h06);
        in_word = '1; in_ready = 1'b1; is_last = 1'b1; dsep = 8'hff;
        vectors++; if (buffer_full !== 1'b1) begin errors++; $display("FAIL pad_buffer_full got %b want 1", buffer_full); end
        wait_ready(n);
        vectors++; if (n !== 8) begin errors++; $display("FAIL abuse_latency got %0d want 8", n); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (out !== BLK4) begin errors++; $display("FAIL abuse_block got %h want %h", out, BLK4); end
        vectors++; if (out_ready !== 1'b1 || last_block !== 1'b1) begin errors++; $display("FAIL abuse_hold got %b%b want 11", out_ready, last_block); end
        in_ready = 1'b0; is_last = 1'b0;
        ack;
        vectors++; if (last_block !== 1'b0 || buffer_full !== 1'b0) begin errors++; $display("FAIL abuse_after_ack got %b%b want 00", last_block, buffer_full); end
        send(64'h0, 1'b1, 3'd0, 8'h1f);
        wait_ready(n);
        vectors++; if (n !== 8) begin errors++; $display("FAIL second_latency got %0d want 8", n); end
        vectors++; if (out !== EMPTY1F) begin errors++; $display("FAIL second_block got %h want %h", out, EMPTY1F); end
        vectors++; if (last_block !== 1'b1) begin errors++; $display("FAIL second_last_block got %b want 1", last_block); end
        ack;
    endtask

    task automatic test_reset_mid_pad;
        int n;
        send(64'h1122334455667788, 1'b1, 3'd4, 8'h06);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        vectors++; if (out !== '0) begin errors++; $display("FAIL async_out got %h want 0", out); end
        vectors++; if (out_ready !== 1'b0 || buffer_full !== 1'b0 || last_block !== 1'b0) begin
            errors++; $display("FAIL async_flags got %b%b%b want 000", out_ready, buffer_full, last_block);
        end
        @(negedge clk);
        reset = 1'b0;
        send(64'h0, 1'b1, 3'd0, 8'h06);
        wait_ready(n);
        vectors++; if (n !== 8) begin errors++; $display("FAIL post_reset_latency got %0d want 8", n); end
        vectors++; if (out !== EMPTY06) begin errors++; $display("FAIL post_reset_block got %h want %h", out, EMPTY06); end
        vectors++; if (last_block !== 1'b1) begin errors++; $display("FAIL post_reset_last_block got %b want 1", last_block); end
        ack;
    endtask

    initial begin
        test_reset;
        test_empty_sha3;
        test_full_then_tail;
        test_boundary;
        test_handshake_abuse;
        test_reset_mid_pad;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "watchdog");
    end
endmodule
